// File: rtl/uart_pkg.sv
// Shared definitions for the UART message sender: parity modes, FSM encodings
// and frame helper functions.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic {
    MSG_IDLE = 1'b0,
    MSG_SEND = 1'b1
  } msg_state_t;

  function automatic int uart_frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic logic uart_parity_bit(input logic [7:0] data, input int data_bits, input int parity);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x = x ^ (data[i] & (i < data_bits));
    end
    return (parity == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-frame UART serializer: start bit, LSB-first data, optional parity and
// stop bits. A new frame may be accepted on the last cycle of the previous one.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int         FRAME_BITS    = uart_frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam logic [15:0] CNT_MAX      = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_DATA_POS = 4'(DATA_BITS);
  localparam logic [3:0]  LAST_POS      = 4'(FRAME_BITS - 1);
  localparam logic [7:0]  DATA_MASK     = 8'((9'd1 << DATA_BITS) - 9'd1);

  tx_state_t   r_state, w_state_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [3:0]  r_pos, w_pos_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic        r_par, w_par_nx;
  logic        r_tx, w_tx_nx;
  logic        w_bit_end;
  logic        w_frame_end;

  assign w_bit_end   = (r_cnt == CNT_MAX);
  assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_pos == LAST_POS);
  assign o_ready     = (r_state == ST_IDLE) || w_frame_end;
  assign o_tx        = r_tx;

  // Next-state and datapath decode for the frame in flight or the one being accepted.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = 16'd0;
    w_pos_nx   = 4'd0;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_tx_nx    = 1'b1;
    if (r_state != ST_IDLE) begin
      w_cnt_nx = w_bit_end ? 16'd0 : r_cnt + 16'd1;
      w_pos_nx = w_bit_end ? r_pos + 4'd1 : r_pos;
    end else begin
      w_pos_nx = 4'd0;
    end
    case (r_state)
      ST_IDLE: begin
        w_tx_nx = 1'b1;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nx = ST_DATA;
          w_tx_nx    = r_shift[0];
        end else begin
          w_tx_nx = 1'b0;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_pos == LAST_DATA_POS)) begin
          w_state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          w_tx_nx    = (PARITY != PAR_NONE) ? r_par : 1'b1;
        end else if (w_bit_end) begin
          w_shift_nx = r_shift >> 1;
          w_tx_nx    = r_shift[1];
        end else begin
          w_tx_nx = r_tx;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nx = ST_STOP;
          w_tx_nx    = 1'b1;
        end else begin
          w_tx_nx = r_par;
        end
      end
      ST_STOP: begin
        w_tx_nx = 1'b1;
        if (w_frame_end) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_STOP;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
    // Accepting a frame overrides the wind-down so back-to-back frames have no gap.
    if (i_start && o_ready) begin
      w_state_nx = ST_START;
      w_cnt_nx   = 16'd0;
      w_pos_nx   = 4'd0;
      w_shift_nx = i_data & DATA_MASK;
      w_par_nx   = uart_parity_bit(i_data, DATA_BITS, PARITY);
      w_tx_nx    = 1'b0;
    end else begin
      w_par_nx = w_par_nx;
    end
  end

  // Serializer state register; the line idles high out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_pos   <= 4'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pos   <= w_pos_nx;
      r_shift <= w_shift_nx;
      r_par   <= w_par_nx;
      r_tx    <= w_tx_nx;
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Sends a MSG_LEN-character message from a writable buffer on each rising edge
// of the asynchronous dtr input, reporting busy and a done pulse.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int                   CLK_DIV   = 5208,
  parameter int                   DATA_BITS = 8,
  parameter int                   PARITY    = PAR_NONE,
  parameter int                   STOP_BITS = 1,
  parameter int                   MSG_LEN   = 4,
  parameter logic [8*MSG_LEN-1:0] MSG_INIT  = "Hola"
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       dtr,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [127:0] INIT_PAD = 128'(MSG_INIT) << (8 * (16 - MSG_LEN));
  localparam logic [3:0]   LAST_IDX = 4'(MSG_LEN - 1);

  logic       r_sync1, r_sync2, r_prev;
  logic [7:0] r_buf [16];
  msg_state_t r_state, w_state_nx;
  logic [3:0] r_idx, w_idx_nx;
  logic       r_busy, w_busy_nx;
  logic       r_done, w_done_nx;
  logic       w_rise, w_wr_ok, w_start, w_core_ready, w_core_tx;
  logic [7:0] w_char;
  logic [3:0] w_idx_inc;

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_wr_ok   = wr_en && (r_state == MSG_IDLE) && ({1'b0, wr_addr} < 5'(MSG_LEN));
  assign w_idx_inc = r_idx + 4'd1;

  // Two-flop synchroniser on dtr followed by the edge-detect history flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= dtr;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Message buffer; entries past MSG_LEN stay at zero and are never addressed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= INIT_PAD[8*(15-i) +: 8];
      end
    end else if (w_wr_ok) begin
      r_buf[wr_addr] <= wr_data;
    end else begin
      r_buf[0] <= r_buf[0];
    end
  end

  // Character sequencer; a same-cycle write to entry 0 is forwarded to the first frame.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    w_start    = 1'b0;
    w_char     = r_buf[r_idx];
    case (r_state)
      MSG_IDLE: begin
        if (w_rise) begin
          w_state_nx = MSG_SEND;
          w_idx_nx   = 4'd0;
          w_busy_nx  = 1'b1;
          w_start    = 1'b1;
          w_char     = (w_wr_ok && (wr_addr == 4'd0)) ? wr_data : r_buf[0];
        end else begin
          w_busy_nx = 1'b0;
        end
      end
      MSG_SEND: begin
        if (w_core_ready && (r_idx == LAST_IDX)) begin
          w_state_nx = MSG_IDLE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end else if (w_core_ready) begin
          w_idx_nx = w_idx_inc;
          w_start  = 1'b1;
          w_char   = r_buf[w_idx_inc];
        end else begin
          w_busy_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = MSG_IDLE;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= MSG_IDLE;
      r_idx   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  uart_tx_core #(
    .CLK_DIV   (CLK_DIV),
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY),
    .STOP_BITS (STOP_BITS)
  ) u_core (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_start (w_start),
    .i_data  (w_char),
    .o_ready (w_core_ready),
    .o_tx    (w_core_tx)
  );

  assign tx   = w_core_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
